// File: rtl/pfxsum_sched.sv
// pfxsum_sched: round-robin job scheduler in front of a prefix-sum engine.
// Grants one requester at a time, launches the engine with a one-cycle
// pulse, waits for the rising edge of the engine's done level, and holds
// the result on a valid/ready response port until it is consumed.
// Optional feature: define PFXSUM_SCHED_TIMEOUT_EN to abort a job that
// waits TIMEOUT cycles for the engine, answering with rsp_err=1, rsp_vec=0.
module pfxsum_sched #(
  parameter int IWIDTH  = 8,
  parameter int V_LEN   = 16,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NREQ-1:0]               req_valid,
  input  logic [NREQ*V_LEN*IWIDTH-1:0]  req_vec,
  output logic [NREQ-1:0]               req_ready,
  output logic                          eng_valid_in,
  output logic [V_LEN*IWIDTH-1:0]       eng_ivec,
  input  logic                          eng_valid_out,
  input  logic [V_LEN*IWIDTH-1:0]       eng_ovec,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [$clog2(NREQ)-1:0]       rsp_id,
  output logic [V_LEN*IWIDTH-1:0]       rsp_vec,
  output logic                          rsp_err,
  output logic [15:0]                   jobs_done
);

  localparam int VW  = V_LEN * IWIDTH;
  localparam int IDW = $clog2(NREQ);

  // Reject parameter sets the arbiter, packing or timer cannot support.
  if (NREQ < 2 || NREQ > 8 || V_LEN < 2 || (V_LEN & (V_LEN - 1)) != 0 || TIMEOUT < 2)
  begin : g_param_check
    $error("pfxsum_sched: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e            state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [NREQ-1:0]   req_ready_q, req_ready_d;
  logic              eng_valid_in_q, eng_valid_in_d;
  logic [VW-1:0]     eng_ivec_q, eng_ivec_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]    rsp_id_q, rsp_id_d;
  logic [VW-1:0]     rsp_vec_q, rsp_vec_d;
  logic [15:0]       jobs_done_q, jobs_done_d;
  logic              eng_prev_q, eng_prev_d;

  logic              grant_found;
  logic [IDW-1:0]    grant_idx;
  logic              done;

`ifdef PFXSUM_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT);
  logic [TW-1:0]     timer_q, timer_d;
  logic              rsp_err_q, rsp_err_d;
`endif

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!grant_found && req_valid[(int'(ptr_q) + i) % NREQ]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'((int'(ptr_q) + i) % NREQ);
      end
    end
  end

  // A job completes only on a fresh low-to-high transition of the done level.
  assign done = eng_valid_out & ~eng_prev_q;

  // Next-state and next-output logic for the scheduler FSM.
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    req_ready_d    = '0;
    eng_valid_in_d = 1'b0;
    eng_ivec_d     = eng_ivec_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_id_d       = rsp_id_q;
    rsp_vec_d      = rsp_vec_q;
    jobs_done_d    = jobs_done_q;
    eng_prev_d     = eng_valid_out;
`ifdef PFXSUM_SCHED_TIMEOUT_EN
    timer_d        = timer_q;
    rsp_err_d      = rsp_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          req_ready_d = NREQ'(1) << grant_idx;
          ptr_d       = grant_idx;
          eng_ivec_d  = req_vec[int'(grant_idx)*VW +: VW];
          rsp_id_d    = grant_idx;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        eng_valid_in_d = 1'b1;
`ifdef PFXSUM_SCHED_TIMEOUT_EN
        timer_d        = '0;
`endif
        state_d        = WAIT;
      end
      WAIT: begin
        if (done) begin
          rsp_vec_d   = eng_ovec;
          rsp_valid_d = 1'b1;
`ifdef PFXSUM_SCHED_TIMEOUT_EN
          rsp_err_d   = 1'b0;
`endif
          state_d     = RESP;
        end
`ifdef PFXSUM_SCHED_TIMEOUT_EN
        else if (timer_q == TW'(TIMEOUT - 1)) begin
          rsp_vec_d   = '0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          state_d     = RESP;
        end else begin
          timer_d     = timer_q + 1'b1;
        end
`endif
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          jobs_done_d = jobs_done_q + 16'd1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any job in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      ptr_q          <= IDW'(NREQ - 1);
      req_ready_q    <= '0;
      eng_valid_in_q <= 1'b0;
      eng_ivec_q     <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_id_q       <= '0;
      rsp_vec_q      <= '0;
      jobs_done_q    <= '0;
      eng_prev_q     <= 1'b0;
`ifdef PFXSUM_SCHED_TIMEOUT_EN
      timer_q        <= '0;
      rsp_err_q      <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      req_ready_q    <= req_ready_d;
      eng_valid_in_q <= eng_valid_in_d;
      eng_ivec_q     <= eng_ivec_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_id_q       <= rsp_id_d;
      rsp_vec_q      <= rsp_vec_d;
      jobs_done_q    <= jobs_done_d;
      eng_prev_q     <= eng_prev_d;
`ifdef PFXSUM_SCHED_TIMEOUT_EN
      timer_q        <= timer_d;
      rsp_err_q      <= rsp_err_d;
`endif
    end
  end

  assign req_ready    = req_ready_q;
  assign eng_valid_in = eng_valid_in_q;
  assign eng_ivec     = eng_ivec_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_vec      = rsp_vec_q;
  assign jobs_done    = jobs_done_q;
`ifdef PFXSUM_SCHED_TIMEOUT_EN
  assign rsp_err      = rsp_err_q;
`else
  assign rsp_err      = 1'b0;
`endif

endmodule

// File: doc/pfxsum_sched.md
PFXSUM_SCHED -- requirements
Module: pfxsum_sched

Interface
REQ-001 SHALL have parameter IWIDTH, default 8, element width in bits.
REQ-002 SHALL have parameter V_LEN, default 16, elements per vector (power of 2, >=2).
REQ-003 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-004 SHALL have parameter TIMEOUT, default 64, max engine wait in cycles (>=2).
REQ-005 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port req_valid  input  NREQ  per-requester job request.
REQ-008 SHALL have port req_vec  input  NREQ*V_LEN*IWIDTH  per-requester vector; slot r at bits [(r+1)*V_LEN*IWIDTH-1 : r*V_LEN*IWIDTH].
REQ-009 SHALL have port req_ready  output  NREQ  one-hot accept strobe.
REQ-010 SHALL have port eng_valid_in  output  1  one-cycle start pulse to the prefix-sum engine.
REQ-011 SHALL have port eng_ivec  output  V_LEN*IWIDTH  vector to the engine.
REQ-012 SHALL have port eng_valid_out  input  1  engine done; level signal, may stay high after completion.
REQ-013 SHALL have port eng_ovec  input  V_LEN*IWIDTH  engine result.
REQ-014 SHALL have port rsp_valid  output  1  response available.
REQ-015 SHALL have port rsp_ready  input  1  response consumer ready.
REQ-016 SHALL have port rsp_id  output  $clog2(NREQ)  index of the served requester.
REQ-017 SHALL have port rsp_vec  output  V_LEN*IWIDTH  result vector.
REQ-018 SHALL have port rsp_err  output  1  response is a timeout error.
REQ-019 SHALL have port jobs_done  output  16  count of completed responses.

Function
REQ-020 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-021 IDLE: if any req_valid is set, grant round-robin starting at index ptr+1 (mod NREQ); assert req_ready[g] for 1 cycle; latch req_vec slot g into eng_ivec and g into rsp_id; go to ISSUE.
REQ-022 IDLE with no req_valid: remain in IDLE, req_ready=0.
REQ-023 ptr SHALL update to g on grant; the last-granted requester has lowest priority next arbitration.
REQ-024 ISSUE: eng_valid_in=1 for exactly 1 cycle; clear timer; go to WAIT.
REQ-025 Done SHALL be the rising edge of eng_valid_out (previous-cycle value registered); a level held high from the prior job SHALL NOT complete the current job.
REQ-026 WAIT: on done, latch eng_ovec into rsp_vec, set rsp_err=0, go to RESP.
REQ-027 RESP: rsp_valid=1; hold rsp_id/rsp_vec/rsp_err stable until rsp_valid&&rsp_ready; then increment jobs_done (wraps 0xFFFF->0) and go to IDLE.
REQ-028 Latency: grant at cycle N, eng_valid_in at N+1, earliest rsp_valid at edge cycle+1.
REQ-029 Back-to-back: a new grant SHALL occur no earlier than the cycle after the handshake.
REQ-030 eng_valid_out edges outside WAIT SHALL be ignored.
REQ-031 req_valid deasserting while not granted SHALL be legal and SHALL drop that requester from arbitration.
REQ-032 eng_ivec SHALL hold its value from grant until the next grant.

Reset
REQ-033 On rst_n low, asynchronously: state=IDLE, ptr=NREQ-1 (requester 0 wins first), req_ready=0, eng_valid_in=0, eng_ivec=0, rsp_valid=0, rsp_id=0, rsp_vec=0, rsp_err=0, jobs_done=0, edge register=0, timer=0.
REQ-034 Reset mid-job SHALL abandon the job with no response; the first post-reset grant SHALL follow REQ-033 priority.

Configuration
REQ-035 Macro PFXSUM_SCHED_TIMEOUT_EN defined: WAIT counts cycles; if timer reaches TIMEOUT-1 with no done, go to RESP with rsp_err=1, rsp_vec=0; a done edge on that same cycle SHALL win (rsp_err=0).
REQ-036 Macro undefined: no timer; WAIT persists until done; rsp_err is constant 0.

Verification
REQ-037 Single job: req_valid=0001, vec elements 1..16 (IWIDTH=8), engine model returns prefix sums -> req_ready=0001 at N, eng_valid_in at N+1 only, rsp_id=0, rsp_vec last element 0x88, jobs_done=1.
REQ-038 Contention: req_valid=1111 held for 4 jobs -> grant order 0,1,2,3 and then 0 again.
REQ-039 Backpressure: rsp_ready=0 for 10 cycles in RESP -> rsp_valid and rsp_vec stable, no new grant, jobs_done unchanged until handshake.
REQ-040 Sticky done: engine keeps eng_valid_out=1 after job 1 -> job 2 does not complete until eng_valid_out falls and rises again.
REQ-041 Timeout (macro defined, TIMEOUT=64): engine never responds -> rsp_valid with rsp_err=1, rsp_vec=0 exactly 64 cycles after WAIT entry; without macro, rsp_valid stays 0 for 1000 cycles.
REQ-042 Reset in WAIT: rst_n low 2 cycles -> all outputs 0 immediately; with req_valid=0110 after release, first grant goes to requester 1.
